// File: rtl/bridge_1xn.sv
// One CPU data master fanned out to NUM_SLAVES SRAM-style slaves by base/mask decode,
// with one-cycle read return and sticky status for accesses that hit no slave.
module bridge_1xn #(
   parameter int                         NUM_SLAVES    = 2,
   parameter int                         XLEN          = 32,
   parameter logic [NUM_SLAVES*XLEN-1:0] SLV_BASE      = {32'h1faf0000, 32'h00000000},
   parameter logic [NUM_SLAVES*XLEN-1:0] SLV_MASK      = {32'hffff0000, 32'hffffc000},
   parameter logic [XLEN-1:0]            DEFAULT_RDATA = 32'hdeadbeef,
   parameter int                         ERR_CNT_W     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_data_en,
   input  logic [3:0]                 cpu_data_wen,
   input  logic [XLEN-1:0]            cpu_data_addr,
   input  logic [XLEN-1:0]            cpu_data_wdata,
   output logic [XLEN-1:0]            cpu_data_rdata,
   output logic [NUM_SLAVES-1:0]      s_en,
   output logic [4*NUM_SLAVES-1:0]    s_wen,
   output logic [XLEN*NUM_SLAVES-1:0] s_addr,
   output logic [XLEN*NUM_SLAVES-1:0] s_wdata,
   input  logic [XLEN*NUM_SLAVES-1:0] s_rdata,
   input  logic                       err_clr,
   output logic                       err_valid,
   output logic [XLEN-1:0]            err_addr,
   output logic [ERR_CNT_W-1:0]       err_cnt
);

   logic [NUM_SLAVES-1:0] w_hit;
   logic [NUM_SLAVES-1:0] w_sel;
   logic                  w_miss;
   logic [NUM_SLAVES-1:0] r_sel_q;
   logic                  r_miss_q;
   logic                  r_err_valid;
   logic [XLEN-1:0]       r_err_addr;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   // Lowest-index slave wins when several windows overlap.
   always_comb begin : decode
      logic w_taken;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_hit   = '0;
      w_sel   = '0;
      w_taken = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_hit[i] = (cpu_data_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN];
         if (w_hit[i] && !w_taken) begin
            w_sel[i] = 1'b1;
            w_taken  = 1'b1;
         end
      end
   end

   assign w_miss = cpu_data_en & ~|w_hit;

   always_comb begin : fan_out
      s_en    = '0;
      s_wen   = '0;
      s_addr  = '0;
      s_wdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         s_en[i]                  = cpu_data_en & w_sel[i];
         s_wen[i*4 +: 4]          = w_sel[i] ? cpu_data_wen : 4'b0000;
         s_addr[i*XLEN +: XLEN]   = cpu_data_addr;
         s_wdata[i*XLEN +: XLEN]  = cpu_data_wdata;
      end
   end

   // Return-path selection only moves on strobed cycles so idle cycles keep mirroring
   // the last slave, which itself holds its read output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         r_sel_q  <= '0;
         r_miss_q <= 1'b0;
      end else if (cpu_data_en) begin
         r_sel_q  <= w_sel;
         r_miss_q <= w_miss;
      end
   end

   always_comb begin : read_mux
      cpu_data_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_sel_q[i]) cpu_data_rdata = cpu_data_rdata | s_rdata[i*XLEN +: XLEN];
      end
      if (r_miss_q) cpu_data_rdata = DEFAULT_RDATA;
   end

   // A clear coinciding with a miss restarts the status at that miss.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cnt   <= '0;
      end else if (err_clr) begin
         r_err_valid <= w_miss;
         r_err_addr  <= w_miss ? cpu_data_addr : '0;
         r_err_cnt   <= w_miss ? ERR_CNT_W'(1) : '0;
      end else if (w_miss) begin
         if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
         if (!r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= cpu_data_addr;
         end
      end
   end

   assign err_valid = r_err_valid;
   assign err_addr  = r_err_addr;
   assign err_cnt   = r_err_cnt;

endmodule
